// File: rtl/adsd_risc_pkg.sv
// adsd_risc_pkg
//   Shared definitions for the ADSD RISC data-memory responder: the CPU data
//   width, the wait-state counter width and the responder FSM encoding.
package adsd_risc_pkg;

  localparam int DATA_W = 16;
  localparam int LAT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_DONE = 3'd4
  } dmem_state_t;

endpackage

// File: rtl/adsd_dmem_array.sv
// adsd_dmem_array
//   DEPTH x DATA_W data storage, DEPTH = 2**AW. Synchronous write and
//   asynchronous (combinational) read. Contents are never cleared.
// Ports
//   clk    in   rising-edge clock
//   we     in   write enable, sampled at the rising edge
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address
//   rdata  out  mem[raddr], combinational
module adsd_dmem_array #(
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adsd_dmem_responder.sv
// adsd_dmem_responder
//   Data-memory responder for the ADSD RISC CPU. Accepts load/store requests
//   from the control path, inserts RD_LAT / WR_LAT wait states and raises
//   stall so the CPU holds its PC until the access completes.
//   Optional feature: define ADSD_DMEM_POSTED_WR_EN for a one-entry posted
//   write buffer (stores complete without stalling while the buffer is free).
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   d_mem_cs     in   access request, held by the CPU while stall=1
//   d_mem_rw_    in   1 = load, 0 = store
//   d_mem_addr   in   word address, only [AW-1:0] used
//   d_mem_wdata  in   store data
//   d_mem_rdata  out  load data, zero unless rdata_valid
//   rdata_valid  out  one-cycle pulse when load data is presented
//   stall        out  access in progress
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for d_mem_cs; the accept cycle counts as a stall cycle
// ST_RD_WAIT | remaining read wait states; cnt = stall cycles left incl. this one
// ST_RD_DONE | load data presented for one cycle, stall released
// ST_WR_WAIT | remaining write wait states; storage written when cnt hits 1
// ST_WR_DONE | store complete, stall released
module adsd_dmem_responder #(
  parameter int DATA_W = adsd_risc_pkg::DATA_W,
  parameter int AW     = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_mem_cs,
  input  logic              d_mem_rw_,
  input  logic [15:0]       d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              rdata_valid,
  output logic              stall
);

  import adsd_risc_pkg::*;

  localparam logic [LAT_W-1:0] RD_CNT0 = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_CNT0 = LAT_W'(WR_LAT - 1);
  localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

  dmem_state_t       state;
  logic [LAT_W-1:0]  cnt;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_rdata;
  logic [AW-1:0]     mem_raddr;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [AW-1:0]     req_addr;
  logic              hold;
  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic              unused_addr;

  // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
  assign req_addr    = d_mem_addr[AW-1:0];
  assign unused_addr = ^d_mem_addr;

  assign accept = (state == ST_IDLE) && d_mem_cs && !hold;
  assign acc_rd = accept && d_mem_rw_;
  assign acc_wr = accept && !d_mem_rw_;

`ifdef ADSD_DMEM_POSTED_WR_EN
  // Stores go to the buffer and never occupy the FSM; the buffer drains
  // over at least one cycle even when WR_LAT is zero.
  localparam bit WR_BLOCKS = 1'b0;
  localparam logic [LAT_W-1:0] PB_CNT0 = (WR_LAT == 0) ? LAT_W'(1) : LAT_W'(WR_LAT);

  logic              pb_valid;
  logic [LAT_W-1:0]  pb_cnt;
  logic [AW-1:0]     pb_addr;
  logic [DATA_W-1:0] pb_data;

  // No forwarding: any request while the buffer is full waits for the drain.
  assign hold = pb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_valid <= 1'b0;
      pb_cnt   <= '0;
    end else if (pb_valid) begin
      if (pb_cnt == CNT_ONE) pb_valid <= 1'b0;
      else                   pb_cnt   <= pb_cnt - CNT_ONE;
    end else if (acc_wr) begin
      pb_valid <= 1'b1;
      pb_cnt   <= PB_CNT0;
      pb_addr  <= req_addr;
      pb_data  <= d_mem_wdata;
    end
  end

  assign mem_we    = pb_valid && (pb_cnt == CNT_ONE) && !rst;
  assign mem_waddr = pb_addr;
  assign mem_wdata = pb_data;
`else
  localparam bit WR_BLOCKS = (WR_LAT != 0);

  logic wr_fire;

  assign hold = 1'b0;

  // WR_LAT 0/1 write at the accept edge straight from the request lines.
  assign wr_fire   = (acc_wr && (WR_LAT <= 1)) ||
                     ((state == ST_WR_WAIT) && (cnt == CNT_ONE));
  assign mem_we    = wr_fire && !rst;
  assign mem_waddr = (state == ST_IDLE) ? req_addr    : addr_q;
  assign mem_wdata = (state == ST_IDLE) ? d_mem_wdata : wdata_q;
`endif

  assign mem_raddr = (state == ST_IDLE) ? req_addr : addr_q;

  always_comb begin
    stall = 1'b0;
    case (state)
      ST_IDLE:    stall = d_mem_cs && (hold || d_mem_rw_ || WR_BLOCKS);
      ST_RD_WAIT: stall = 1'b1;
      ST_WR_WAIT: stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_rd) begin
            addr_q <= req_addr;
            if (RD_LAT == 1) begin
              rdata_q <= mem_rdata;
              state   <= ST_RD_DONE;
            end else begin
              cnt   <= RD_CNT0;
              state <= ST_RD_WAIT;
            end
          end else if (acc_wr && WR_BLOCKS) begin
            addr_q  <= req_addr;
            wdata_q <= d_mem_wdata;
            if (WR_LAT == 1) begin
              state <= ST_WR_DONE;
            end else begin
              cnt   <= WR_CNT0;
              state <= ST_WR_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt == CNT_ONE) begin
            rdata_q <= mem_rdata;
            cnt     <= '0;
            state   <= ST_RD_DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_WR_WAIT: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= ST_WR_DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        // cs still high in a DONE cycle belongs to the finishing access.
        ST_RD_DONE: state <= ST_IDLE;
        ST_WR_DONE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign rdata_valid = (state == ST_RD_DONE);
  assign d_mem_rdata = rdata_valid ? rdata_q : '0;

  adsd_dmem_array #(
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_adsd_dmem_responder.sv
module tb_adsd_dmem_responder;

  localparam int RD_LAT = 2;
`ifdef ADSD_DMEM_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  // Expected stall lengths for the default instance (WR_LAT=1).
  localparam int WS  = POSTED ? 0 : 1;   // store into an idle responder
  localparam int WW  = 1;                // store right after a store
  localparam int RAW = POSTED ? 1 : 0;   // extra load stall right after a store

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, rw = 1'b1;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        rvalid, stall;

  logic        cs0 = 1'b0, rw0 = 1'b1;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic [15:0] rdata0;
  logic        rvalid0, stall0;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_q0[$];

  adsd_dmem_responder u_dut (
    .clk(clk), .rst(rst), .d_mem_cs(cs), .d_mem_rw_(rw), .d_mem_addr(addr),
    .d_mem_wdata(wdata), .d_mem_rdata(rdata), .rdata_valid(rvalid), .stall(stall)
  );

  adsd_dmem_responder #(.WR_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .d_mem_cs(cs0), .d_mem_rw_(rw0), .d_mem_addr(addr0),
    .d_mem_wdata(wdata0), .d_mem_rdata(rdata0), .rdata_valid(rvalid0), .stall(stall0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop expected load data on every rdata_valid pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(rdata), 32'hDEAD);
        else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end else begin
        chk("rdata_idle_zero", 32'(rdata), 32'h0);
      end
      if (rvalid0 === 1'b1) begin
        if (exp_q0.size() == 0) chk("unexpected_valid0", 32'(rdata0), 32'hDEAD);
        else chk("rdata0", 32'(rdata0), 32'(exp_q0.pop_front()));
      end
    end
  end

  // Called just after a rising edge; holds cs until stall drops, then one
  // more edge (the DONE cycle) before releasing cs.
  task automatic access(input bit which, input bit rd, input logic [15:0] a,
                        input logic [15:0] wd, input int exp_stall, input string nm);
    int n = 0;
    if (which) begin cs0 = 1'b1; rw0 = rd; addr0 = a; wdata0 = wd; end
    else       begin cs  = 1'b1; rw  = rd; addr  = a; wdata  = wd; end
    @(negedge clk);
    while ((which ? stall0 : stall) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    if (which) cs0 = 1'b0; else cs = 1'b0;
  endtask

  initial begin
    int v0, c0;
    // reset state
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_valid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic store/load
    access(0, 0, 16'h0012, 16'hBEEF, WS, "st_12_stall");
    exp_q.push_back(16'hBEEF);
    access(0, 1, 16'h0012, 16'h0, RD_LAT + RAW, "ld_12_stall");

    // address wrap
    access(0, 0, 16'h0105, 16'h1234, WS, "st_105_stall");
    exp_q.push_back(16'h1234);
    access(0, 1, 16'h0005, 16'h0, RD_LAT + RAW, "ld_05_wrap_stall");

    // reset in the accept cycle of a store must not write
    access(0, 0, 16'h0040, 16'h5555, WS, "st_40_stall");
    repeat (2) begin @(posedge clk); #1; end
    cs = 1'b1; rw = 1'b0; addr = 16'h0040; wdata = 16'hAAAA; rst = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(16'h5555);
    access(0, 1, 16'h0040, 16'h0, RD_LAT, "ld_40_after_rst_stall");

    // reset two cycles in the middle of a load
    v0 = n_valid;
    cs = 1'b1; rw = 1'b1; addr = 16'h0012;
    @(posedge clk); #1;
    cs = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrd_rst_stall", 32'(stall), 32'h0);
    chk("midrd_rst_valid", 32'(rvalid), 32'h0);
    chk("midrd_rst_state", 32'(u_dut.state), 32'(adsd_risc_pkg::ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrd_no_valid", 32'(n_valid - v0), 32'h0);
    exp_q.push_back(16'hBEEF);
    access(0, 1, 16'h0012, 16'h0, RD_LAT, "ld_12_post_rst_stall");

    // back-to-back loads with cs held through RD_DONE
    v0 = n_valid; c0 = cyc;
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h1234);
    access(0, 1, 16'h0012, 16'h0, RD_LAT, "b2b_ld1_stall");
    access(0, 1, 16'h0005, 16'h0, RD_LAT, "b2b_ld2_stall");
    chk("b2b_cycles", 32'(cyc - c0), 32'(2 * (RD_LAT + 1)));
    chk("b2b_pulses", 32'(n_valid - v0), 32'h2);

    // cs dropped after acceptance: load still completes
    v0 = n_valid;
    exp_q.push_back(16'h5555);
    cs = 1'b1; rw = 1'b1; addr = 16'h0040;
    @(posedge clk); #1;
    cs = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("cs_drop_pulse", 32'(n_valid - v0), 32'h1);

    // store, store, load to one address
    access(0, 0, 16'h0077, 16'h1111, WS, "stst_st1_stall");
    access(0, 0, 16'h0077, 16'h2222, WW, "stst_st2_stall");
    exp_q.push_back(16'h2222);
    access(0, 1, 16'h0077, 16'h0, RD_LAT + RAW, "stst_ld_stall");

    // WR_LAT=0 instance
    access(1, 0, 16'h0003, 16'h00FF, 0, "wl0_st_stall");
    exp_q0.push_back(16'h00FF);
    access(1, 1, 16'h0003, 16'h0, RD_LAT + RAW, "wl0_ld_stall");

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("scoreboard0_drained", 32'(exp_q0.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
